// File: rtl/rv32i_multicycle_controller.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB with memory handshakes, watchdog and retire counter.
// Latency: 3 (branch/jump), 4 (ALU/LUI/AUIPC/store), 5 (load) cycles with zero-wait memories.
// Backpressure: stalls in FETCH/MEM until imem_ready/dmem_ready; halts with bus_error after MEM_TIMEOUT cycles.
module rv32i_multicycle_controller #(
  parameter int MEM_TIMEOUT     = 16,
  parameter bit TRAP_ON_ILLEGAL = 1'b1,
  parameter int CNT_W           = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic [2:0]       wb_sel,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic             use_pc_as_alu_a,
  output logic             mem_read,
  output logic             mem_write,
  output logic             branch,
  output logic             jump,
  output logic             jalr,
  output logic [2:0]       state,
  output logic             halted,
  output logic             illegal_instr,
  output logic             bus_error,
  output logic [CNT_W-1:0] retire_count
);

  localparam logic [2:0] S_BOOT   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // Watchdog counter only needs to reach MEM_TIMEOUT-1
  localparam int            WD_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  logic [2:0]       r_state;
  logic [2:0]       w_state_nxt;
  logic [WD_W-1:0]  r_wd_cnt;
  logic             r_halted;
  logic             r_illegal;
  logic             r_bus_err;
  logic [CNT_W-1:0] r_retire_cnt;

  logic       w_is_load, w_is_store, w_is_branch, w_is_jal, w_is_jalr, w_known;
  logic       w_dec_alu_src, w_dec_use_pc;
  logic [1:0] w_dec_alu_op;
  logic [2:0] w_dec_wb_sel;
  logic       w_timeout, w_retire, w_set_illegal, w_set_bus_err;

  // funct3/funct7 belong to the datapath; they never influence sequencing
  logic w_unused_funct;
  assign w_unused_funct = ^{funct3, funct7};

  assign w_is_load   = (opcode == OPC_LOAD);
  assign w_is_store  = (opcode == OPC_STORE);
  assign w_is_branch = (opcode == OPC_BRANCH);
  assign w_is_jal    = (opcode == OPC_JAL);
  assign w_is_jalr   = (opcode == OPC_JALR);

  assign w_timeout = (MEM_TIMEOUT > 0) && (r_wd_cnt == WD_LAST);

  // Per-opcode static decode and legality check
  always_comb begin
    w_known       = 1'b1;
    w_dec_alu_src = 1'b0;
    w_dec_alu_op  = 2'b00;
    w_dec_use_pc  = 1'b0;
    w_dec_wb_sel  = 3'b000;
    case (opcode)
      OPC_OP:     w_dec_alu_op = 2'b10;
      OPC_OPIMM:  begin w_dec_alu_src = 1'b1; w_dec_alu_op = 2'b11; end
      OPC_LOAD:   begin w_dec_alu_src = 1'b1; w_dec_wb_sel = 3'b001; end
      OPC_STORE:  w_dec_alu_src = 1'b1;
      OPC_BRANCH: w_dec_alu_op = 2'b01;
      OPC_JAL:    w_dec_wb_sel = 3'b010;
      OPC_JALR:   begin w_dec_alu_src = 1'b1; w_dec_wb_sel = 3'b010; end
      OPC_LUI:    w_dec_wb_sel = 3'b011;
      OPC_AUIPC:  begin w_dec_alu_src = 1'b1; w_dec_use_pc = 1'b1; w_dec_wb_sel = 3'b100; end
      default:    w_known = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_BOOT;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; unused encodings fall back to BOOT
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_BOOT:   w_state_nxt = S_FETCH;
      S_FETCH: begin
        if (imem_ready)     w_state_nxt = S_DECODE;
        else if (w_timeout) w_state_nxt = S_HALT;
      end
      S_DECODE: begin
        if (w_known)              w_state_nxt = S_EXEC;
        else if (TRAP_ON_ILLEGAL) w_state_nxt = S_HALT;
        else                      w_state_nxt = S_FETCH;
      end
      S_EXEC: begin
        if (w_is_branch || w_is_jal || w_is_jalr) w_state_nxt = S_FETCH;
        else if (w_is_load || w_is_store)         w_state_nxt = S_MEM;
        else                                      w_state_nxt = S_WB;
      end
      S_MEM: begin
        if (dmem_ready)     w_state_nxt = w_is_load ? S_WB : S_FETCH;
        else if (w_timeout) w_state_nxt = S_HALT;
      end
      S_WB:     w_state_nxt = S_FETCH;
      S_HALT:   w_state_nxt = S_HALT;
      default:  w_state_nxt = S_BOOT;
    endcase
  end

  // Output strobes from state and handshake inputs
  always_comb begin
    imem_req        = 1'b0;
    dmem_req        = 1'b0;
    ir_write        = 1'b0;
    pc_write        = 1'b0;
    reg_write       = 1'b0;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    branch          = 1'b0;
    jump            = 1'b0;
    jalr            = 1'b0;
    alu_src         = 1'b0;
    alu_op          = 2'b00;
    use_pc_as_alu_a = 1'b0;
    wb_sel          = 3'b000;
    w_retire        = 1'b0;
    w_set_illegal   = 1'b0;
    w_set_bus_err   = 1'b0;
    if (r_state == S_EXEC || r_state == S_MEM || r_state == S_WB) begin
      alu_src         = w_dec_alu_src;
      alu_op          = w_dec_alu_op;
      use_pc_as_alu_a = w_dec_use_pc;
      wb_sel          = w_dec_wb_sel;
    end
    case (r_state)
      S_FETCH: begin
        imem_req      = 1'b1;
        ir_write      = imem_ready;
        w_set_bus_err = !imem_ready && w_timeout;
      end
      S_DECODE: begin
        if (!w_known) begin
          if (TRAP_ON_ILLEGAL) begin
            w_set_illegal = 1'b1;
          end else begin
            pc_write = 1'b1;
            w_retire = 1'b1;
          end
        end
      end
      S_EXEC: begin
        if (w_is_branch || w_is_jal || w_is_jalr) begin
          branch   = w_is_branch;
          jump     = w_is_jal;
          jalr     = w_is_jalr;
          reg_write = w_is_jal || w_is_jalr;
          pc_write = 1'b1;
          w_retire = 1'b1;
        end
      end
      S_MEM: begin
        dmem_req      = 1'b1;
        mem_read      = w_is_load;
        mem_write     = w_is_store;
        pc_write      = dmem_ready && w_is_store;
        w_retire      = dmem_ready && w_is_store;
        w_set_bus_err = !dmem_ready && w_timeout;
      end
      S_WB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        w_retire  = 1'b1;
      end
      default: ;
    endcase
  end

  // Watchdog: clear on entry to a wait state, count cycles without ready
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wd_cnt <= '0;
    end else if ((w_state_nxt != r_state) && (w_state_nxt == S_FETCH || w_state_nxt == S_MEM)) begin
      r_wd_cnt <= '0;
    end else if ((MEM_TIMEOUT > 0) && !w_timeout &&
                 ((r_state == S_FETCH && !imem_ready) || (r_state == S_MEM && !dmem_ready))) begin
      r_wd_cnt <= r_wd_cnt + WD_W'(1);
    end
  end

  // Sticky halt flags and retired-instruction counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_halted     <= 1'b0;
      r_illegal    <= 1'b0;
      r_bus_err    <= 1'b0;
      r_retire_cnt <= '0;
    end else begin
      if (w_state_nxt == S_HALT) r_halted  <= 1'b1;
      if (w_set_illegal)         r_illegal <= 1'b1;
      if (w_set_bus_err)         r_bus_err <= 1'b1;
      if (w_retire)              r_retire_cnt <= r_retire_cnt + CNT_W'(1);
    end
  end

  assign state         = r_state;
  assign halted        = r_halted;
  assign illegal_instr = r_illegal;
  assign bus_error     = r_bus_err;
  assign retire_count  = r_retire_cnt;

endmodule

// File: tb/tb_rv32i_multicycle_controller.sv
// Scoreboard bench: per-cycle expectations queued as stimulus is driven, compared at the falling edge.
// u0: MEM_TIMEOUT=4, trap on illegal, 4-bit counter. u1: defaults but skips illegal opcodes.
module tb_rv32i_multicycle_controller;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JR  = 7'b1100111;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUI = 7'b0010111;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  // strobe vector bit positions
  localparam logic [9:0] IMR = 10'b1000000000;
  localparam logic [9:0] DMR = 10'b0100000000;
  localparam logic [9:0] IRW = 10'b0010000000;
  localparam logic [9:0] PCW = 10'b0001000000;
  localparam logic [9:0] RGW = 10'b0000100000;
  localparam logic [9:0] MRD = 10'b0000010000;
  localparam logic [9:0] MWR = 10'b0000001000;
  localparam logic [9:0] BRS = 10'b0000000100;
  localparam logic [9:0] JPS = 10'b0000000010;
  localparam logic [9:0] JRS = 10'b0000000001;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic [6:0] funct7 = '0;
  logic       imem_ready = 1'b0;
  logic       dmem_ready = 1'b0;

  logic a_imem_req, a_dmem_req, a_ir_write, a_pc_write, a_reg_write, a_alu_src, a_use_pc;
  logic a_mem_read, a_mem_write, a_branch, a_jump, a_jalr, a_halted, a_illegal, a_bus_error;
  logic [2:0] a_wb_sel, a_state;
  logic [1:0] a_alu_op;
  logic [3:0] a_retire_count;

  logic b_imem_req, b_dmem_req, b_ir_write, b_pc_write, b_reg_write, b_alu_src, b_use_pc;
  logic b_mem_read, b_mem_write, b_branch, b_jump, b_jalr, b_halted, b_illegal, b_bus_error;
  logic [2:0] b_wb_sel, b_state;
  logic [1:0] b_alu_op;
  logic [31:0] b_retire_count;

  rv32i_multicycle_controller #(.MEM_TIMEOUT(4), .TRAP_ON_ILLEGAL(1'b1), .CNT_W(4)) u0 (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(a_imem_req), .dmem_req(a_dmem_req), .ir_write(a_ir_write), .pc_write(a_pc_write),
    .reg_write(a_reg_write), .wb_sel(a_wb_sel), .alu_src(a_alu_src), .alu_op(a_alu_op),
    .use_pc_as_alu_a(a_use_pc), .mem_read(a_mem_read), .mem_write(a_mem_write),
    .branch(a_branch), .jump(a_jump), .jalr(a_jalr), .state(a_state), .halted(a_halted),
    .illegal_instr(a_illegal), .bus_error(a_bus_error), .retire_count(a_retire_count)
  );

  rv32i_multicycle_controller #(.MEM_TIMEOUT(16), .TRAP_ON_ILLEGAL(1'b0), .CNT_W(32)) u1 (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(b_imem_req), .dmem_req(b_dmem_req), .ir_write(b_ir_write), .pc_write(b_pc_write),
    .reg_write(b_reg_write), .wb_sel(b_wb_sel), .alu_src(b_alu_src), .alu_op(b_alu_op),
    .use_pc_as_alu_a(b_use_pc), .mem_read(b_mem_read), .mem_write(b_mem_write),
    .branch(b_branch), .jump(b_jump), .jalr(b_jalr), .state(b_state), .halted(b_halted),
    .illegal_instr(b_illegal), .bus_error(b_bus_error), .retire_count(b_retire_count)
  );

  always #5 clk = ~clk;

  wire [9:0] a_strb = {a_imem_req, a_dmem_req, a_ir_write, a_pc_write, a_reg_write,
                       a_mem_read, a_mem_write, a_branch, a_jump, a_jalr};
  wire [6:0] a_dec  = {a_alu_src, a_alu_op, a_use_pc, a_wb_sel};
  wire [2:0] a_flg  = {a_halted, a_illegal, a_bus_error};
  wire [9:0] b_strb = {b_imem_req, b_dmem_req, b_ir_write, b_pc_write, b_reg_write,
                       b_mem_read, b_mem_write, b_branch, b_jump, b_jalr};
  wire [6:0] b_dec  = {b_alu_src, b_alu_op, b_use_pc, b_wb_sel};
  wire [2:0] b_flg  = {b_halted, b_illegal, b_bus_error};

  typedef struct {
    string      tag;
    logic [2:0] st;
    logic [9:0] strb;
    logic [6:0] dec;
    logic [3:0] ret;
    logic [2:0] flg;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  int         n_total = 0;
  int         n_bad   = 0;
  logic [3:0] exp_ret = '0;
  logic [2:0] exp_flg = '0;   // {halted, illegal, bus_error}

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // expected static decode per opcode
  function automatic logic [6:0] dec_of(input logic [6:0] op);
    case (op)
      OP_R:    return {1'b0, 2'b10, 1'b0, 3'b000};
      OP_I:    return {1'b1, 2'b11, 1'b0, 3'b000};
      OP_LD:   return {1'b1, 2'b00, 1'b0, 3'b001};
      OP_ST:   return {1'b1, 2'b00, 1'b0, 3'b000};
      OP_BR:   return {1'b0, 2'b01, 1'b0, 3'b000};
      OP_JAL:  return {1'b0, 2'b00, 1'b0, 3'b010};
      OP_JR:   return {1'b1, 2'b00, 1'b0, 3'b010};
      OP_LUI:  return {1'b0, 2'b00, 1'b0, 3'b011};
      OP_AUI:  return {1'b1, 2'b00, 1'b1, 3'b100};
      default: return 7'd0;
    endcase
  endfunction

  // compare each queued expectation in the cycle it belongs to
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      chk({mon_e.tag, ".state"}, 32'(a_state), 32'(mon_e.st));
      chk({mon_e.tag, ".strobes"}, 32'(a_strb), 32'(mon_e.strb));
      chk({mon_e.tag, ".decode"}, 32'(a_dec), 32'(mon_e.dec));
      chk({mon_e.tag, ".retired"}, 32'(a_retire_count), 32'(mon_e.ret));
      chk({mon_e.tag, ".flags"}, 32'(a_flg), 32'(mon_e.flg));
    end
  end

  // drive one cycle of inputs just after the rising edge and queue what u0 must show
  task automatic step(input string tag, input logic [6:0] op, input logic ir, input logic dr,
                      input logic [2:0] st, input logic [9:0] strb, input logic [6:0] dec);
    exp_t e;
    @(posedge clk);
    #1;
    opcode     = op;
    funct3     = 3'($urandom);
    funct7     = 7'($urandom);
    imem_ready = ir;
    dmem_ready = dr;
    e.tag = tag; e.st = st; e.strb = strb; e.dec = dec; e.ret = exp_ret; e.flg = exp_flg;
    sb_q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst = 1'b1;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    #1;
    chk("rst.state", 32'(a_state), 32'd0);
    chk("rst.strobes", 32'(a_strb), 32'd0);
    chk("rst.decode", 32'(a_dec), 32'd0);
    chk("rst.flags", 32'(a_flg), 32'd0);
    chk("rst.retired", 32'(a_retire_count), 32'd0);
    #1;
    rst = 1'b0;
    exp_ret = '0;
    exp_flg = '0;
    #1;
    chk("boot.state", 32'(a_state), 32'd0);
  endtask

  // full instruction with iw fetch wait cycles and dw data wait cycles
  task automatic do_instr(input string tag, input logic [6:0] op, input int iw, input int dw);
    logic [6:0] d;
    d = dec_of(op);
    for (int k = 0; k <= iw; k++)
      step({tag, ".F"}, op, (k == iw), 1'b0, 3'd1, IMR | ((k == iw) ? IRW : 10'd0), 7'd0);
    step({tag, ".D"}, op, 1'b0, 1'b0, 3'd2, 10'd0, 7'd0);
    case (op)
      OP_BR: begin
        step({tag, ".E"}, op, 1'b0, 1'b0, 3'd3, BRS | PCW, d);
        exp_ret++;
      end
      OP_JAL: begin
        step({tag, ".E"}, op, 1'b0, 1'b0, 3'd3, JPS | RGW | PCW, d);
        exp_ret++;
      end
      OP_JR: begin
        step({tag, ".E"}, op, 1'b0, 1'b0, 3'd3, JRS | RGW | PCW, d);
        exp_ret++;
      end
      OP_LD, OP_ST: begin
        step({tag, ".E"}, op, 1'b0, 1'b0, 3'd3, 10'd0, d);
        for (int k = 0; k <= dw; k++)
          step({tag, ".M"}, op, 1'b0, (k == dw), 3'd4,
               DMR | ((op == OP_LD) ? MRD : MWR) | ((op == OP_ST && k == dw) ? PCW : 10'd0), d);
        if (op == OP_ST) exp_ret++;
        else begin
          step({tag, ".W"}, op, 1'b0, 1'b0, 3'd5, RGW | PCW, d);
          exp_ret++;
        end
      end
      default: begin
        step({tag, ".E"}, op, 1'b0, 1'b0, 3'd3, 10'd0, d);
        step({tag, ".W"}, op, 1'b0, 1'b0, 3'd5, RGW | PCW, d);
        exp_ret++;
      end
    endcase
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    do_reset();

    // zero-wait ADD then LW, followed by assorted opcodes and waits
    do_instr("add", OP_R, 0, 0);
    do_instr("lw", OP_LD, 0, 0);
    do_instr("addi", OP_I, 1, 0);
    do_instr("lui", OP_LUI, 0, 0);
    do_instr("auipc", OP_AUI, 2, 0);
    do_instr("beq", OP_BR, 0, 0);
    do_instr("jalr", OP_JR, 0, 0);
    do_instr("sw", OP_ST, 0, 3);
    do_instr("lw2", OP_LD, 0, 2);

    // reset in the middle of a stalled load access
    step("mid.F", OP_LD, 1'b1, 1'b0, 3'd1, IMR | IRW, 7'd0);
    step("mid.D", OP_LD, 1'b0, 1'b0, 3'd2, 10'd0, 7'd0);
    step("mid.E", OP_LD, 1'b0, 1'b0, 3'd3, 10'd0, dec_of(OP_LD));
    step("mid.M", OP_LD, 1'b0, 1'b0, 3'd4, DMR | MRD, dec_of(OP_LD));
    do_reset();
    step("mid.F2", OP_LD, 1'b0, 1'b0, 3'd1, IMR, 7'd0);

    // fetch never answered: four FETCH cycles then bus error halt, which is sticky
    do_reset();
    for (int k = 0; k < 4; k++) step("tof.F", OP_R, 1'b0, 1'b0, 3'd1, IMR, 7'd0);
    exp_flg = 3'b101;
    step("tof.H", OP_R, 1'b1, 1'b1, 3'd6, 10'd0, 7'd0);
    step("tof.H2", OP_R, 1'b1, 1'b1, 3'd6, 10'd0, 7'd0);

    // ready on the last allowed fetch cycle wins
    do_reset();
    do_instr("late", OP_R, 3, 0);

    // data access never answered
    do_reset();
    step("tom.F", OP_LD, 1'b1, 1'b0, 3'd1, IMR | IRW, 7'd0);
    step("tom.D", OP_LD, 1'b0, 1'b0, 3'd2, 10'd0, 7'd0);
    step("tom.E", OP_LD, 1'b0, 1'b0, 3'd3, 10'd0, dec_of(OP_LD));
    for (int k = 0; k < 4; k++) step("tom.M", OP_LD, 1'b0, 1'b0, 3'd4, DMR | MRD, dec_of(OP_LD));
    exp_flg = 3'b101;
    step("tom.H", OP_LD, 1'b0, 1'b1, 3'd6, 10'd0, 7'd0);

    // illegal opcode: u0 traps, u1 skips it as a NOP
    do_reset();
    step("ill.F", OP_BAD, 1'b1, 1'b0, 3'd1, IMR | IRW, 7'd0);
    step("ill.D", OP_BAD, 1'b0, 1'b0, 3'd2, 10'd0, 7'd0);
    #3;
    chk("skip.D.state", 32'(b_state), 32'd2);
    chk("skip.D.strobes", 32'(b_strb), 32'(PCW));
    chk("skip.D.decode", 32'(b_dec), 32'd0);
    exp_flg = 3'b110;
    step("ill.H", OP_BAD, 1'b0, 1'b0, 3'd6, 10'd0, 7'd0);
    #3;
    chk("skip.state", 32'(b_state), 32'd1);
    chk("skip.retired", b_retire_count, 32'd1);
    chk("skip.flags", 32'(b_flg), 32'd0);

    // 17 JALs wrap the 4-bit retire counter to 1
    do_reset();
    for (int n = 0; n < 17; n++) do_instr("jal", OP_JAL, 0, 0);
    @(posedge clk);
    #1;
    chk("wrap.retired", 32'(a_retire_count), 32'd1);

    @(negedge clk);
    @(negedge clk);
    chk("queue.drained", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/rv32i_multicycle_controller.md
Name: rv32i_multicycle_controller

Overview:
Multi-cycle successor to the single-cycle decoder/controller for the RV32I core. It sequences each instruction through fetch, decode, execute, memory and writeback states and handshakes with instruction and data memories that may take several cycles. Two parameters add a bus-timeout watchdog and a trap-on-illegal-opcode mode. It also keeps a retired-instruction counter. It sits between the instruction register/PC/regfile datapath and the memory ports.

Parameters:
MEM_TIMEOUT, 16, max wait cycles for imem_ready/dmem_ready before bus error; 0 disables the watchdog
TRAP_ON_ILLEGAL, 1, 1: unknown opcode halts the core; 0: unknown opcode is skipped as a NOP
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
opcode  input  7  IR[6:0], stable from DECODE until the instruction retires
funct3  input  3  IR[14:12], passed through for the datapath, no effect on sequencing
funct7  input  7  IR[31:25], passed through for the datapath, no effect on sequencing
imem_ready  input  1  instruction word valid this cycle
dmem_ready  input  1  data access complete this cycle
imem_req  output  1  instruction fetch request
dmem_req  output  1  data access request
ir_write  output  1  latch imem data into IR
pc_write  output  1  load next PC; the datapath selects PC+4 or the target using branch/jump/jalr
reg_write  output  1  regfile write strobe
wb_sel  output  3  000 ALU, 001 MEM, 010 PC+4, 011 IMM, 100 ALU (PC+imm)
alu_src  output  1  ALU B operand: 1 = immediate
alu_op  output  2  00 add, 01 branch compare, 10 R-type, 11 I-type
use_pc_as_alu_a  output  1  ALU A operand is the PC
mem_read  output  1  load access
mem_write  output  1  store access
branch  output  1  branch instruction in EXEC
jump  output  1  JAL in EXEC
jalr  output  1  JALR in EXEC
state  output  3  current state encoding
halted  output  1  sticky: core stopped
illegal_instr  output  1  sticky: halted on an unknown opcode
bus_error  output  1  sticky: halted on a memory timeout
retire_count  output  CNT_W  instructions retired, wraps modulo 2^CNT_W

Behaviour:
- State encoding: BOOT=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6. Encodings 7 and above are unreachable and must recover to BOOT.
- Reset (async, any time, including mid-access):
  - state=BOOT; halted, illegal_instr, bus_error, retire_count and the timeout counter all clear.
  - BOOT drives every output to 0 and moves to FETCH on the next edge.
- Strobes are combinational from state plus handshake inputs and are 0 outside the states listed below.
- Static decode (alu_src, alu_op, use_pc_as_alu_a, wb_sel) is driven only in EXEC, MEM and WB; it is 0 elsewhere.
- Per-opcode static decode:
  - OP 0110011: alu_op=10, wb=000.
  - OP-IMM 0010011: alu_src=1, alu_op=11, wb=000.
  - LOAD 0000011: alu_src=1, wb=001.
  - STORE 0100011: alu_src=1.
  - BRANCH 1100011: alu_op=01.
  - JAL 1101111: wb=010.
  - JALR 1100111: alu_src=1, wb=010.
  - LUI 0110111: wb=011.
  - AUIPC 0010111: alu_src=1, use_pc=1, wb=100.
- FETCH: imem_req=1. When imem_ready=1: ir_write=1 and go to DECODE.
- DECODE: no strobes.
  - Known opcode: go to EXEC.
  - Unknown opcode with TRAP_ON_ILLEGAL=1: go to HALT and set illegal_instr.
  - Unknown opcode with TRAP_ON_ILLEGAL=0: pc_write=1, retire, go to FETCH.
- EXEC:
  - BRANCH: branch=1, pc_write=1, retire, go to FETCH.
  - JAL/JALR: jump or jalr=1, reg_write=1, pc_write=1, retire, go to FETCH.
  - LOAD/STORE: go to MEM.
  - Others: go to WB.
- MEM: dmem_req=1, with mem_read (LOAD) or mem_write (STORE) held until dmem_ready.
  - On dmem_ready, STORE: pc_write=1, retire, go to FETCH.
  - On dmem_ready, LOAD: go to WB.
- WB: reg_write=1, pc_write=1, retire, go to FETCH.
- Retire: retire_count increments by 1 on each edge where the retire condition holds.
- Watchdog (MEM_TIMEOUT>0):
  - The counter clears on entry to FETCH or MEM and increments each cycle that ready is low.
  - If ready is still low when the counter equals MEM_TIMEOUT-1: go to HALT and set bus_error. Total wait is MEM_TIMEOUT cycles.
  - Ready arriving in that same cycle wins: no error.
- HALT: all strobes 0, halted=1. Leaves only via rst.
- Latency with zero-wait memory:
  - ALU, LUI, AUIPC: 4 cycles (FETCH, DECODE, EXEC, WB).
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - BRANCH, JAL, JALR: 3 cycles.

Test Plan:
- rst pulse mid-MEM with dmem_req=1 -> all outputs 0 immediately; state=0; one cycle later state=1 and imem_req=1; retire_count=0.
- Zero-wait ADD (0110011) then LW (0000011) -> states 1,2,3,5 then 1,2,3,4,5. LW WB shows reg_write=1, wb_sel=001. retire_count=2 after 9 cycles.
- SW with dmem_ready held low 3 cycles -> mem_write=1 and dmem_req=1 for 4 cycles; pc_write in the 4th; no reg_write; retire_count+1.
- MEM_TIMEOUT=4, imem_ready never high -> HALT after 4 FETCH cycles, bus_error=1, halted=1; ready arriving on the 4th cycle instead -> no error.
- Opcode 1111111 with TRAP_ON_ILLEGAL=1 -> HALT, illegal_instr=1. With TRAP_ON_ILLEGAL=0 -> pc_write in DECODE, retire_count+1, back to FETCH.
- CNT_W=4, 17 JALs -> retire_count wraps to 1; each JAL shows jump=1, reg_write=1, wb_sel=010 in EXEC.
